gpreg_wb_queue: RTL and testbench

Writeback queue that sits in front of the write port of the GPR bank and is its only writer. Execute and load units push completed register results through a valid/ready handshake. The block buffers them in order in a small FIFO and drains one entry per cycle onto the bank's `isWrD`/`isQwD`/`idRegD`/`dataD` port. A lookup port reports whether a read register has a pending, uncommitted write, so decode can stall or take forwarded data.

---
 rtl/gpreg_pkg.sv | 49 ++++
 rtl/gpreg_wb_match.sv | 47 ++++
 rtl/gpreg_wb_queue.sv | 113 +++++++++++
 tb/tb_gpreg_wb_queue.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpreg_pkg.sv
// Shared GPR definitions: register id constants, storage-key mapping and the
// set of ids that are never written. The GPR bank and the writeback queue both
// import this so they agree on where every id lives.
package gpreg_pkg;

    // Control-register (CC) space occupies ids 0x50..0x5F.
    localparam logic [6:0] REG_CC_BASE = 7'h50;

    // Opcode operand pseudo-registers, immediate and zero register.
    localparam logic [6:0] REG_OP_D   = 7'h58;
    localparam logic [6:0] REG_OP_S   = 7'h59;
    localparam logic [6:0] REG_OP_T   = 7'h5A;
    localparam logic [6:0] REG_OP_IMM = 7'h5B;
    localparam logic [6:0] REG_IMM    = 7'h5E;
    localparam logic [6:0] REG_ZZR    = 7'h5F;

    // {isC, idx}: identifies the physical storage an id touches.
    typedef logic [6:0] regKey_t;

    // One queued writeback.
    typedef struct packed {
        logic        qw;
        logic [6:0]  id;
        logic [63:0] data;
    } wbEntry_t;

    function automatic logic isCcSpace(input logic [6:0] id);
        return id[6] & (id[5:4] == 2'b01);
    endfunction

    // Lo and hi halves (id[6]) share an index outside the CC space.
    function automatic regKey_t regKey(input logic [6:0] id);
        if (isCcSpace(id))
            return {1'b1, 2'b00, id[3:0]};
        else
            return {1'b0, id[5:0]};
    endfunction

    // Ids that have no backing storage; writes to them are dropped.
    function automatic logic isDiscard(input logic [6:0] id);
        logic hit;
        case (id)
            REG_OP_D, REG_OP_S, REG_OP_T, REG_OP_IMM, REG_IMM, REG_ZZR: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpreg_wb_match.sv
// Lookup of a decode read id against the queued writebacks. Slots arrive in
// age order (slot 0 oldest); the newest matching entry decides forwarding.
module gpreg_wb_match
    import gpreg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]    entValid,
    input  logic [DEPTH-1:0]    entQw,
    input  logic [DEPTH*7-1:0]  entId,
    input  logic [DEPTH*64-1:0] entData,
    input  logic [6:0]          lkId,
    output logic                lkBusy,
    output logic                lkFwd,
    output logic [63:0]         lkData
);

    logic        hit;
    logic        hitQw;
    logic [6:0]  hitId;
    logic [63:0] hitData;

    // Ascending scan with overwrite: the last (newest) match wins.
    always_comb begin
        hit     = 1'b0;
        hitQw   = 1'b0;
        hitId   = '0;
        hitData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entValid[i] && (regKey(entId[i*7 +: 7]) == regKey(lkId))) begin
                hit     = 1'b1;
                hitQw   = entQw[i];
                hitId   = entId[i*7 +: 7];
                hitData = entData[i*64 +: 64];
            end
        end
    end

    // Forward only when the newest writer fully defines the value the bank
    // would return: a quadword to exactly this id, and not a hi-half read.
    always_comb begin
        lkBusy = hit & ~isDiscard(lkId);
        lkFwd  = lkBusy & hitQw & (hitId == lkId) & (~lkId[6] | isCcSpace(lkId));
        lkData = lkFwd ? hitData : '0;
    end

endmodule

// File: rtl/gpreg_wb_queue.sv
// In-order writeback FIFO in front of the GPR bank write port. Accepts one
// result per cycle, retires one per cycle when the bank port is free, and
// exposes a lookup so decode can see pending writes.
module gpreg_wb_queue
    import gpreg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inValid,
    output logic        inReady,
    input  logic        inQw,
    input  logic [6:0]  inId,
    input  logic [63:0] inData,
    input  logic        wbEnable,
    output logic        isWrD,
    output logic        isQwD,
    output logic [6:0]  idRegD,
    output logic [63:0] dataD,
    input  logic [6:0]  lkId,
    output logic        lkBusy,
    output logic        lkFwd,
    output logic [63:0] lkData,
    output logic [4:0]  count
);

    localparam int PTRW = $clog2(DEPTH);

    logic [PTRW-1:0] headReg;
    logic [PTRW-1:0] tailReg;
    logic [4:0]      countReg;

    // Entry storage; validity comes from head/count, so no reset needed.
    logic            memQw   [DEPTH];
    logic [6:0]      memId   [DEPTH];
    logic [63:0]     memData [DEPTH];

    logic pushEn;
    logic popEn;
    logic notEmpty;

    logic [DEPTH-1:0]    entValid;
    logic [DEPTH-1:0]    entQw;
    logic [DEPTH*7-1:0]  entId;
    logic [DEPTH*64-1:0] entData;

    assign notEmpty = (countReg != 5'd0);
    // Full is judged on the registered count: no pass-through when full.
    assign inReady  = rst_n & (countReg < 5'(DEPTH));
    // Discard-set handshakes complete but leave no entry behind.
    assign pushEn   = inValid & inReady & ~isDiscard(inId);
    assign isWrD    = notEmpty & wbEnable;
    assign popEn    = isWrD;
    assign count    = countReg;

    // Head entry drives the bank port; zeros when nothing is queued.
    always_comb begin
        isQwD  = notEmpty ? memQw[headReg]   : 1'b0;
        idRegD = notEmpty ? memId[headReg]   : 7'd0;
        dataD  = notEmpty ? memData[headReg] : 64'd0;
    end

    // Pointer and occupancy update; reset drops every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
        end else begin
            if (pushEn)
                tailReg <= tailReg + PTRW'(1);
            if (popEn)
                headReg <= headReg + PTRW'(1);
            countReg <= countReg + {4'd0, pushEn} - {4'd0, popEn};
        end
    end

    // Write the accepted result at the tail slot.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            memQw[tailReg]   <= inQw;
            memId[tailReg]   <= inId;
            memData[tailReg] <= inData;
        end
    end

    // Present entries to the matcher in age order, oldest first.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gSlot
            logic [PTRW-1:0] slotIdx;
            assign slotIdx                = headReg + PTRW'(gi);
            assign entValid[gi]           = (5'(gi) < countReg);
            assign entQw[gi]              = memQw[slotIdx];
            assign entId[gi*7 +: 7]       = memId[slotIdx];
            assign entData[gi*64 +: 64]   = memData[slotIdx];
        end
    endgenerate

    gpreg_wb_match #(
        .DEPTH(DEPTH)
    ) uMatch (
        .entValid(entValid),
        .entQw(entQw),
        .entId(entId),
        .entData(entData),
        .lkId(lkId),
        .lkBusy(lkBusy),
        .lkFwd(lkFwd),
        .lkData(lkData)
    );

endmodule

// File: tb/tb_gpreg_wb_queue.sv
// Scoreboard bench for the GPR writeback queue: accepted results are queued as
// expectations and compared against every bank write, in order.
module tb_gpreg_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic        inQw = 1'b0;
    logic [6:0]  inId = 7'd0;
    logic [63:0] inData = 64'd0;
    logic        wbEnable = 1'b1;
    logic        isWrD;
    logic        isQwD;
    logic [6:0]  idRegD;
    logic [63:0] dataD;
    logic [6:0]  lkId = 7'd0;
    logic        lkBusy;
    logic        lkFwd;
    logic [63:0] lkData;
    logic [4:0]  count;

    typedef struct packed {
        logic        qw;
        logic [6:0]  id;
        logic [63:0] data;
    } exp_t;

    exp_t sbq[$];
    int vectors = 0;
    int miscompares = 0;

    gpreg_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady), .inQw(inQw), .inId(inId), .inData(inData),
        .wbEnable(wbEnable),
        .isWrD(isWrD), .isQwD(isQwD), .idRegD(idRegD), .dataD(dataD),
        .lkId(lkId), .lkBusy(lkBusy), .lkFwd(lkFwd), .lkData(lkData),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic bit dropId(input logic [6:0] id);
        return (id == 7'h58) || (id == 7'h59) || (id == 7'h5A) ||
               (id == 7'h5B) || (id == 7'h5E) || (id == 7'h5F);
    endfunction

    function automatic logic [6:0] keyOf(input logic [6:0] id);
        if (id >= 7'h50 && id <= 7'h5F)
            return {3'b100, id[3:0]};
        return {1'b0, id[5:0]};
    endfunction

    // Inputs change here, well clear of both edges.
    task automatic toDrive();
        @(posedge clk);
        #2;
    endtask

    task automatic toSample();
        @(negedge clk);
    endtask

    // Write-port monitor: occupancy vs scoreboard, then pop, then record push.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            vectors++;
            if (count !== 5'(sbq.size())) begin
                miscompares++;
                $display("FAIL occupancy: count=%0d expected %0d", count, sbq.size());
            end
            if (isWrD === 1'b1) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: id=%h data=%h with nothing queued", idRegD, dataD);
                end else begin
                    e = sbq.pop_front();
                    if ({isQwD, idRegD, dataD} !== {e.qw, e.id, e.data}) begin
                        miscompares++;
                        $display("FAIL write_order: got qw=%b id=%h data=%h expected qw=%b id=%h data=%h",
                                 isQwD, idRegD, dataD, e.qw, e.id, e.data);
                    end else begin
                        $display("write id=%h qw=%b data=%h", idRegD, isQwD, dataD);
                    end
                end
            end
            if (inValid === 1'b1 && inReady === 1'b1 && !dropId(inId))
                sbq.push_back('{qw: inQw, id: inId, data: inData});
        end
    end

    task automatic test_reset();
        inValid = 1'b1; inId = 7'h05; inQw = 1'b1; inData = 64'hAA; lkId = 7'h05; wbEnable = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (inReady !== 1'b0) begin miscompares++; $display("FAIL reset_inReady: got %b expected 0", inReady); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
        vectors++; if (isWrD !== 1'b0) begin miscompares++; $display("FAIL reset_isWrD: got %b expected 0", isWrD); end
        vectors++; if ({isQwD, idRegD, dataD} !== 72'd0) begin miscompares++; $display("FAIL reset_port: got %b/%h/%h expected zeros", isQwD, idRegD, dataD); end
        vectors++; if ({lkBusy, lkFwd, lkData} !== 66'd0) begin miscompares++; $display("FAIL reset_lookup: got %b/%b/%h expected zeros", lkBusy, lkFwd, lkData); end
        inValid = 1'b0;
        toDrive();
        rst_n = 1'b1;
        toSample();
        vectors++; if (inReady !== 1'b1) begin miscompares++; $display("FAIL reset_release_inReady: got %b expected 1", inReady); end
        $display("reset checked");
    endtask

    task automatic test_basic_drain();
        toDrive();
        inValid = 1'b1; inQw = 1'b1; inId = 7'h05; inData = 64'h1122334455667788; wbEnable = 1'b1;
        toSample();
        vectors++; if (inReady !== 1'b1) begin miscompares++; $display("FAIL basic_inReady: got %b expected 1", inReady); end
        toDrive();
        inValid = 1'b0;
        toSample();
        vectors++; if (isWrD !== 1'b1) begin miscompares++; $display("FAIL basic_isWrD: got %b expected 1", isWrD); end
        vectors++; if (idRegD !== 7'h05) begin miscompares++; $display("FAIL basic_idRegD: got %h expected 05", idRegD); end
        vectors++; if (dataD !== 64'h1122334455667788) begin miscompares++; $display("FAIL basic_dataD: got %h expected 1122334455667788", dataD); end
        toDrive();
        toSample();
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL basic_drained: count=%0d expected 0", count); end
        $display("basic drain checked");
    endtask

    task automatic test_full_backpressure();
        for (int i = 0; i <= DEPTH; i++) begin
            toDrive();
            wbEnable = 1'b0; inValid = 1'b1; inQw = i[0];
            inId = 7'(i + 1); inData = 64'hF000_0000_0000_0000 | 64'(i);
            toSample();
            vectors++;
            if (inReady !== (i < DEPTH)) begin
                miscompares++;
                $display("FAIL full_inReady[%0d]: got %b expected %b", i, inReady, (i < DEPTH));
            end
        end
        toDrive();
        wbEnable = 1'b1;
        toSample();
        vectors++; if (inReady !== 1'b0) begin miscompares++; $display("FAIL full_no_passthrough: inReady=%b expected 0", inReady); end
        vectors++; if (isWrD !== 1'b1) begin miscompares++; $display("FAIL full_drain_start: isWrD=%b expected 1", isWrD); end
        toDrive();
        toSample();
        vectors++; if (inReady !== 1'b1) begin miscompares++; $display("FAIL full_held_accept: inReady=%b expected 1", inReady); end
        toDrive();
        inValid = 1'b0;
        for (int c = 0; c < 20 && count !== 5'd0; c++) toSample();
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL full_drain_timeout: count=%0d expected 0", count); end
        $display("full/backpressure checked");
    endtask

    task automatic test_discard();
        logic [6:0] ids [2];
        ids[0] = 7'h5F; ids[1] = 7'h5A;
        for (int i = 0; i < 2; i++) begin
            toDrive();
            wbEnable = 1'b1; inValid = 1'b1; inQw = 1'b1; inId = ids[i]; inData = 64'hDEAD;
            toSample();
            vectors++; if (inReady !== 1'b1) begin miscompares++; $display("FAIL discard_handshake[%h]: inReady=%b expected 1", ids[i], inReady); end
        end
        toDrive();
        inValid = 1'b0;
        toSample();
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL discard_count: got %0d expected 0", count); end
        vectors++; if (isWrD !== 1'b0) begin miscompares++; $display("FAIL discard_isWrD: got %b expected 0", isWrD); end
        $display("discard checked");
    endtask

    task automatic test_forwarding();
        toDrive();
        wbEnable = 1'b0; inValid = 1'b1; inQw = 1'b1; inId = 7'h03; inData = 64'hAAAA_0000_0000_0003; lkId = 7'h03;
        toDrive();
        inQw = 1'b0; inId = 7'h43; inData = 64'hBBBB_0000_0000_0043;
        toSample();
        vectors++; if (lkFwd !== 1'b1 || lkData !== 64'hAAAA_0000_0000_0003) begin miscompares++; $display("FAIL fwd_single: fwd=%b data=%h expected 1/aaaa000000000003", lkFwd, lkData); end
        toDrive();
        inValid = 1'b0;
        toSample();
        vectors++; if (lkBusy !== 1'b1) begin miscompares++; $display("FAIL fwd_busy: got %b expected 1", lkBusy); end
        vectors++; if (lkFwd !== 1'b0 || lkData !== 64'd0) begin miscompares++; $display("FAIL fwd_hi_newest: fwd=%b data=%h expected 0/0", lkFwd, lkData); end
        toDrive();
        wbEnable = 1'b1;
        toDrive();
        toSample();
        vectors++; if (lkBusy !== 1'b1) begin miscompares++; $display("FAIL fwd_busy_until_commit: got %b expected 1", lkBusy); end
        toDrive();
        toSample();
        vectors++; if (lkBusy !== 1'b0) begin miscompares++; $display("FAIL fwd_busy_cleared: got %b expected 0", lkBusy); end
        $display("forwarding checked");
    endtask

    task automatic test_cc_space();
        toDrive();
        wbEnable = 1'b0; inValid = 1'b1; inQw = 1'b1; inId = 7'h51; inData = 64'hCCCC_1234_5678_0051; lkId = 7'h51;
        toDrive();
        inValid = 1'b0;
        toSample();
        vectors++; if (lkFwd !== 1'b1 || lkData !== 64'hCCCC_1234_5678_0051) begin miscompares++; $display("FAIL cc_fwd: fwd=%b data=%h expected 1/cccc123456780051", lkFwd, lkData); end
        toDrive();
        lkId = 7'h11;
        toSample();
        vectors++; if (lkBusy !== 1'b0) begin miscompares++; $display("FAIL cc_alias: lkBusy=%b expected 0", lkBusy); end
        toDrive();
        wbEnable = 1'b1;
        for (int c = 0; c < 10 && count !== 5'd0; c++) toSample();
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL cc_drain_timeout: count=%0d expected 0", count); end
        $display("cc space checked");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            toDrive();
            wbEnable = 1'b0; inValid = 1'b1; inQw = 1'b1; inId = 7'(8 + i); inData = 64'(i) << 8;
        end
        toDrive();
        inValid = 1'b0;
        toSample();
        vectors++; if (count !== 5'd3) begin miscompares++; $display("FAIL midrst_fill: count=%0d expected 3", count); end
        #1 wbEnable = 1'b1;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        sbq.delete();
        #1;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL midrst_count: got %0d expected 0", count); end
        vectors++; if (isWrD !== 1'b0) begin miscompares++; $display("FAIL midrst_isWrD: got %b expected 0", isWrD); end
        toDrive();
        inValid = 1'b1; inQw = 1'b0; inId = 7'h07; inData = 64'h0707_0707_0707_0707;
        toDrive();
        inValid = 1'b0;
        toSample();
        vectors++; if (isWrD !== 1'b1 || idRegD !== 7'h07) begin miscompares++; $display("FAIL midrst_after: isWrD=%b id=%h expected 1/07", isWrD, idRegD); end
        toDrive();
        toSample();
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL midrst_drained: count=%0d expected 0", count); end
        $display("reset mid-operation checked");
    endtask

    task automatic test_back_to_back();
        logic        expBusy;
        logic        expFwd;
        logic [63:0] expData;
        logic        found;
        exp_t        e;
        for (int n = 0; n < 80; n++) begin
            toDrive();
            inValid  = ($urandom_range(0, 3) != 0);
            wbEnable = (n < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            inQw     = $urandom_range(0, 1) == 1;
            inId     = ($urandom_range(0, 3) == 0) ? 7'(7'h50 + $urandom_range(0, 15)) : 7'($urandom_range(0, 127));
            inData   = {$urandom, $urandom};
            if (sbq.size() != 0 && $urandom_range(0, 2) != 0) begin
                e = sbq[$urandom_range(0, sbq.size() - 1)];
                lkId = $urandom_range(0, 1) ? e.id : (e.id ^ 7'h40);
            end else begin
                lkId = 7'($urandom_range(0, 127));
            end
            #1;
            expBusy = 1'b0; expFwd = 1'b0; expData = 64'd0; found = 1'b0;
            for (int i = sbq.size() - 1; i >= 0 && !found; i--) begin
                if (keyOf(sbq[i].id) == keyOf(lkId)) begin
                    found = 1'b1;
                    expFwd = sbq[i].qw && (sbq[i].id == lkId) && (!lkId[6] || (lkId >= 7'h50 && lkId <= 7'h5F));
                end
                if (found && expFwd) expData = sbq[i].data;
            end
            expBusy = found && !dropId(lkId);
            expFwd  = expFwd && expBusy;
            if (!expFwd) expData = 64'd0;
            vectors++;
            if ({lkBusy, lkFwd, lkData} !== {expBusy, expFwd, expData}) begin
                miscompares++;
                $display("FAIL lookup[%0d] id=%h: got %b/%b/%h expected %b/%b/%h",
                         n, lkId, lkBusy, lkFwd, lkData, expBusy, expFwd, expData);
            end
        end
        toDrive();
        inValid = 1'b0; wbEnable = 1'b1;
        for (int c = 0; c < 20 && count !== 5'd0; c++) toSample();
        vectors++; if (count !== 5'd0 || sbq.size() != 0) begin miscompares++; $display("FAIL b2b_drain: count=%0d queued=%0d expected 0/0", count, sbq.size()); end
        $display("back-to-back checked");
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_full_backpressure();
        test_discard();
        test_forwarding();
        test_cc_space();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
